ktane_input_capture: RTL and testbench
======================================

Name: ktane_input_capture

Overview:
Parametrised memory-mapped input-capture peripheral on the CPU data bus, alongside the existing module memory map. It synchronises and debounces NUM_INPUTS raw switch inputs (button, morse keys, keypad). Edges are qualified per channel by a programmable mode, latched as sticky events and queued as channel/edge records in an event FIFO. The CPU reads events in order instead of polling raw pins.

Parameters:
NUM_INPUTS, 4, channel count, 1..8
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before the debounced level changes; must be > NUM_INPUTS
FIFO_DEPTH, 8, event FIFO entries, power of two, 2..64
BASE_ADDR, 16'hC000, word address of register 0; block decodes BASE_ADDR..BASE_ADDR+4

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset
addr  input  16  bus word address
data  input  16  bus write data
we  input  1  write strobe, one cycle
re  input  1  read strobe, one cycle; only needed for side-effect reads
q  output  16  registered read data, zero when addr is outside the block
irq  output  1  high while the FIFO is non-empty
pins  input  NUM_INPUTS  raw asynchronous inputs, active-high

Behaviour:
- Reset (reset=0, async) clears the following: sync flops, debounce counters, debounced levels, EVENT, MODE, FIFO pointers, count, OVF, q and irq; all are 0.
- Sync: two-flop synchroniser per pin; the output is s[i].
- Debounce, per channel:
  - If s[i]==lvl[i], cnt[i]<=0.
  - Otherwise cnt[i] increments. On the cycle it reaches DEBOUNCE_CYCLES-1, lvl[i] toggles and cnt[i]<=0.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Edge: rise[i]=lvl rising, fall[i]=lvl falling, each valid for one cycle.
- MODE (offset 2, RW): bits [2i+1:2i] per channel. 00 off, 01 rise, 10 fall, 11 both. Unused bits read 0.
- Qualified event: sets EVENT[i] (sticky) and sets pend[i] with pend_edge[i] (1=rise).
- Arbiter: each cycle the lowest-index set pend[i] is pushed as the record {1'b1, 6'b0, pend_edge, 5'b0, ch[2:0]}, and that pend bit clears.
- Pending bits for other channels wait. DEBOUNCE_CYCLES>NUM_INPUTS guarantees none are overwritten.
- FIFO full on push: the record is dropped, the pend bit still clears, and STATUS.OVF is set (sticky).
- Register map (offset from BASE_ADDR):
  - 0 RAW, RO: {zeros, lvl}.
  - 1 EVENT, W1C: write data bit i=1 clears EVENT[i]. A set and a clear of the same bit in the same cycle leaves the bit set.
  - 2 MODE, RW.
  - 3 STATUS: {OVF[15], full[14], empty[13], zeros, count[6:0]}. Writing bit15=1 clears OVF. Other bits are RO.
  - 4 POP, RO with side effect. q = head record, or 16'h0000 when empty. A read with re=1 pops the head when non-empty. A pop while empty has no effect.
- Read latency: q is registered one cycle after addr/re. q reflects the pre-pop head and pre-write register state. A write and a read in the same cycle both take effect.
- Simultaneous push and pop:
  - When full: both occur, count is unchanged, no OVF.
  - When empty: the pop is ignored and the push occurs.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- irq = (count!=0), registered.
- An asynchronous reset mid-debounce or mid-FIFO discards all state. No event is produced on the first cycle after reset.

Decomposition:
- Shared package ktane_io_pkg:
  - Register offset constants REG_RAW..REG_POP.
  - MODE encodings MODE_OFF/RISE/FALL/BOTH.
  - Record field positions: VALID=15, EDGE=8, CH=2:0.
- Sub-module ktane_debounce: one per channel via generate. It contains the sync, counter, lvl, rise and fall.
- FIFO, arbiter and register file are in the top level.

Test Plan:
- DEBOUNCE_CYCLES=16, MODE=16'h0001, ch0 glitches high for 10 cycles -> no change to RAW, EVENT=0, FIFO empty, irq=0.
- Ch0 held high 30 cycles, MODE ch0=01 -> RAW=0x0001; EVENT=0x0001; POP reads 0x8100; irq falls one cycle after the pop; a second POP reads 0x0000.
- MODE=16'h00FF, ch1 and ch3 rise in the same cycle -> FIFO holds 0x8101 then 0x8103 in that order; count=2.
- FIFO_DEPTH=4, six qualified events -> STATUS=0xC004 (OVF|full|count 4); the first four records are popped intact. Writing 0x8000 to STATUS clears OVF.
- EVENT=0x000F, write 0x0005 to offset 1 -> EVENT reads 0x000A. A simultaneous ch0 event with a clear of bit0 -> bit0 remains 1.
- Assert reset=0 mid-debounce with a FIFO count of 3 -> all registers read 0 and irq=0 immediately (async). After release no spurious event while the pin stays low.

Source files
------------

// File: rtl/ktane_io_pkg.sv
// Shared register offsets, MODE encodings and event-record layout for the KTANE input-capture block.
package ktane_io_pkg;

  localparam logic [2:0] REG_RAW    = 3'd0;
  localparam logic [2:0] REG_EVENT  = 3'd1;
  localparam logic [2:0] REG_MODE   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_POP    = 3'd4;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int REC_VALID = 15;
  localparam int REC_EDGE  = 8;
  localparam int REC_CH_HI = 2;
  localparam int REC_CH_LO = 0;

  function automatic logic [15:0] make_rec(input logic rise_edge, input logic [2:0] ch);
    logic [15:0] r;
    r = '0;
    r[REC_VALID] = 1'b1;
    r[REC_EDGE] = rise_edge;
    r[REC_CH_HI:REC_CH_LO] = ch;
    return r;
  endfunction

endpackage

// File: rtl/ktane_debounce.sv
// One channel: two-flop synchroniser, stability counter and debounced level with one-cycle rise/fall pulses.
// Edge pulses are registered and coincide with the cycle the new debounced level first appears.
module ktane_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d  = ~lvl_q;
        rise_d = ~lvl_q;
        fall_d = lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ktane_input_capture.sv
// Memory-mapped input capture: debounced switch channels, per-channel edge qualification, sticky events and an event FIFO.
// Read data is registered one cycle after addr/re; FIFO overflow drops the record and sets a sticky OVF flag.
module ktane_input_capture
  import ktane_io_pkg::*;
#(
  parameter int          NUM_INPUTS      = 4,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] BASE_ADDR       = 16'hC000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [15:0]           addr,
  input  logic [15:0]           data,
  input  logic                  we,
  input  logic                  re,
  output logic [15:0]           q,
  output logic                  irq,
  input  logic [NUM_INPUTS-1:0] pins
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int MW   = 2 * NUM_INPUTS;

  logic [NUM_INPUTS-1:0] lvl, rise, fall;
  logic [NUM_INPUTS-1:0] qual_rise, qual_fall, qual_any;
  logic [NUM_INPUTS-1:0] event_q, event_d, pend_q, pend_d, pend_edge_q, pend_edge_d, arb_clr;
  logic [MW-1:0]         mode_q, mode_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  ovf_q, ovf_d, irq_q, irq_d;
  logic [15:0]           q_q, q_d;
  logic [15:0]           mem [FIFO_DEPTH];
  logic [15:0]           off;
  logic                  in_blk, wr_event, wr_mode, wr_status, full, empty, pop, push, ovf_set;
  logic                  arb_vld, arb_edge;
  logic [2:0]            arb_ch;
  logic                  unused_data;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
    ktane_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .reset  (reset),
      .pin_i  (pins[gi]),
      .lvl_o  (lvl[gi]),
      .rise_o (rise[gi]),
      .fall_o (fall[gi])
    );
  end

  assign off         = addr - BASE_ADDR;
  assign in_blk      = (off <= 16'd4);
  assign wr_event    = we && in_blk && (off[2:0] == REG_EVENT);
  assign wr_mode     = we && in_blk && (off[2:0] == REG_MODE);
  assign wr_status   = we && in_blk && (off[2:0] == REG_STATUS);
  assign unused_data = ^data;

  always_comb begin
    mode_e m;
    m         = MODE_OFF;
    qual_rise = '0;
    qual_fall = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      m = mode_e'(mode_q[2*i +: 2]);
      qual_rise[i] = rise[i] && (m == MODE_RISE || m == MODE_BOTH);
      qual_fall[i] = fall[i] && (m == MODE_FALL || m == MODE_BOTH);
    end
  end
  assign qual_any = qual_rise | qual_fall;

  // Descending scan so the lowest-index pending channel is the one that sticks.
  always_comb begin
    arb_vld  = 1'b0;
    arb_edge = 1'b0;
    arb_ch   = '0;
    arb_clr  = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        arb_vld    = 1'b1;
        arb_edge   = pend_edge_q[i];
        arb_ch     = 3'(i);
        arb_clr    = '0;
        arb_clr[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d      = (pend_q & ~arb_clr) | qual_any;
    pend_edge_d = pend_edge_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (qual_any[i]) pend_edge_d[i] = qual_rise[i];
    end
  end

  assign full    = (count_q == CNTW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = re && in_blk && (off[2:0] == REG_POP) && !empty;
  assign push    = arb_vld && (!full || pop);
  assign ovf_set = arb_vld && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CNTW'(push) - CNTW'(pop);
    irq_d    = (count_d != '0);
    event_d  = (event_q & ~(wr_event ? data[NUM_INPUTS-1:0] : '0)) | qual_any;
    mode_d   = wr_mode ? data[MW-1:0] : mode_q;
    ovf_d    = ovf_set || (ovf_q && !(wr_status && data[15]));
    q_d      = '0;
    if (in_blk) begin
      case (off[2:0])
        REG_RAW:    q_d = 16'(lvl);
        REG_EVENT:  q_d = 16'(event_q);
        REG_MODE:   q_d = 16'(mode_q);
        REG_STATUS: q_d = {ovf_q, full, empty, 6'b0, 7'(count_q)};
        REG_POP:    q_d = empty ? 16'h0000 : mem[rd_ptr_q];
        default:    q_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= make_rec(arb_edge, arb_ch);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      event_q     <= '0;
      pend_q      <= '0;
      pend_edge_q <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      q_q         <= '0;
    end else begin
      event_q     <= event_d;
      pend_q      <= pend_d;
      pend_edge_q <= pend_edge_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      q_q         <= q_d;
    end
  end

  assign q   = q_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_ktane_input_capture.sv
// Scenario bench for ktane_input_capture: expected event records queue up as pins are driven and are checked on POP reads.
module tb_ktane_input_capture;

  localparam int          N    = 4;
  localparam logic [15:0] BASE = 16'hC000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   addr  = 16'h0000;
  logic [15:0]   data  = 16'h0000;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [15:0]   q;
  logic          irq;
  logic [N-1:0]  pins  = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] sb[$];

  ktane_input_capture #(
    .NUM_INPUTS(N), .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data), .we(we), .re(re),
    .q(q), .irq(irq), .pins(pins)
  );

  always #5 clock = ~clock;

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [2:0] o, input logic [15:0] v);
    @(negedge clock);
    addr = BASE + 16'(o); data = v; we = 1'b1;
    @(negedge clock);
    we = 1'b0; addr = 16'h0000; data = 16'h0000;
  endtask

  task automatic rd(input logic [2:0] o, output logic [15:0] v);
    @(negedge clock);
    addr = BASE + 16'(o); re = 1'b1;
    @(negedge clock);
    v = q; re = 1'b0; addr = 16'h0000;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    n_checks++;
    if (q !== 16'h0000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got q=%h irq=%b, need q=0000 irq=0", q, irq);
    end
    idle(2); reset = 1'b1; idle(2);
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_raw: got %h need 0000", v); end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_event: got %h need 0000", v); end
    rd(3'd2, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_mode: got %h need 0000", v); end
    rd(3'd3, v); n_checks++;
    if (v !== 16'h2000) begin n_fail++; $display("FAIL reset_status: got %h need 2000", v); end
    rd(3'd5, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL out_of_range: got %h need 0000", v); end
  endtask

  task automatic test_glitch;
    logic [15:0] v;
    wr(3'd2, 16'h0001);
    @(negedge clock); pins[0] = 1'b1;
    idle(10); pins[0] = 1'b0;
    idle(30);
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch_raw: got %h need 0000", v); end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL glitch_event: got %h need 0000", v); end
    rd(3'd3, v); n_checks++;
    if (v !== 16'h2000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL glitch_fifo: got status=%h irq=%b need 2000 irq=0", v, irq);
    end
  endtask

  task automatic test_single;
    logic [15:0] v, e;
    @(negedge clock); pins[0] = 1'b1; sb.push_back(16'h8100);
    idle(30);
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL single_raw: got %h need 0001", v); end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL single_event: got %h need 0001", v); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq_high: got %b need 1", irq); end
    rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
    if (v !== e) begin n_fail++; $display("FAIL single_pop: got %h need %h", v, e); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_low: got %b need 0", irq); end
    rd(3'd4, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL single_pop_empty: got %h need 0000", v); end
    wr(3'd1, 16'h0001);
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL single_event_clr: got %h need 0000", v); end
    @(negedge clock); pins[0] = 1'b0;
    idle(30);
    rd(3'd3, v); n_checks++;
    if (v !== 16'h2000) begin n_fail++; $display("FAIL single_fall_ignored: got %h need 2000", v); end
  endtask

  task automatic test_simultaneous;
    logic [15:0] v, e;
    wr(3'd2, 16'h00FF);
    @(negedge clock); pins[1] = 1'b1; pins[3] = 1'b1;
    sb.push_back(16'h8101); sb.push_back(16'h8103);
    idle(30);
    rd(3'd3, v); n_checks++;
    if (v !== 16'h0002) begin n_fail++; $display("FAIL simul_status: got %h need 0002", v); end
    @(negedge clock); pins[1] = 1'b0; pins[3] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL simul_pop_rise%0d: got %h need %h", k, v, e); end
    end
    sb.push_back(16'h8001); sb.push_back(16'h8003);
    idle(30);
    for (int k = 0; k < 2; k++) begin
      rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL simul_pop_fall%0d: got %h need %h", k, v, e); end
    end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h000A) begin n_fail++; $display("FAIL simul_event: got %h need 000a", v); end
    wr(3'd1, 16'h000F);
  endtask

  task automatic test_overflow;
    logic [15:0] v, e;
    @(negedge clock); pins[2:0] = 3'b111;
    sb.push_back(16'h8100); sb.push_back(16'h8101); sb.push_back(16'h8102);
    idle(30);
    @(negedge clock); pins[2:0] = 3'b000;
    sb.push_back(16'h8000);
    idle(30);
    rd(3'd3, v); n_checks++;
    if (v !== 16'hC004) begin n_fail++; $display("FAIL ovf_status: got %h need c004", v); end
    for (int k = 0; k < 4; k++) begin
      rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL ovf_pop%0d: got %h need %h", k, v, e); end
    end
    rd(3'd3, v); n_checks++;
    if (v !== 16'hA000) begin n_fail++; $display("FAIL ovf_sticky: got %h need a000", v); end
    wr(3'd3, 16'h8000);
    rd(3'd3, v); n_checks++;
    if (v !== 16'h2000) begin n_fail++; $display("FAIL ovf_clear: got %h need 2000", v); end
    wr(3'd1, 16'h000F);
  endtask

  task automatic test_w1c;
    logic [15:0] v, e;
    int ones;
    @(negedge clock); pins = 4'hF;
    for (int k = 0; k < 4; k++) sb.push_back(16'h8100 | 16'(k));
    idle(30);
    rd(3'd1, v); n_checks++;
    if (v !== 16'h000F) begin n_fail++; $display("FAIL w1c_all_set: got %h need 000f", v); end
    wr(3'd1, 16'h0005);
    rd(3'd1, v); n_checks++;
    if (v !== 16'h000A) begin n_fail++; $display("FAIL w1c_partial: got %h need 000a", v); end
    for (int k = 0; k < 4; k++) begin
      rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL w1c_pop%0d: got %h need %h", k, v, e); end
    end
    // Clear bit0 and read EVENT every cycle while a ch0 fall arrives: the set must win once.
    ones = 0;
    @(negedge clock);
    pins[0] = 1'b0; sb.push_back(16'h8000);
    addr = BASE + 16'd1; data = 16'h0001; we = 1'b1; re = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (q[0] === 1'b1) ones++;
    end
    we = 1'b0; re = 1'b0; addr = 16'h0000; data = 16'h0000;
    n_checks++;
    if (ones != 1) begin n_fail++; $display("FAIL w1c_set_wins: bit0 seen set %0d cycles, need 1", ones); end
    rd(3'd4, v); e = (sb.size() > 0) ? sb.pop_front() : 16'h0000; n_checks++;
    if (v !== e) begin n_fail++; $display("FAIL w1c_pop_fall: got %h need %h", v, e); end
    wr(3'd1, 16'h000F);
  endtask

  task automatic test_reset_mid;
    logic [15:0] v;
    @(negedge clock); pins[3:1] = 3'b000;
    idle(30);
    rd(3'd3, v); n_checks++;
    if (v !== 16'h0003 || irq !== 1'b1) begin
      n_fail++; $display("FAIL mid_status: got %h irq=%b need 0003 irq=1", v, irq);
    end
    @(negedge clock); pins[0] = 1'b1;
    idle(8);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (q !== 16'h0000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: got q=%h irq=%b need 0000 0", q, irq);
    end
    sb.delete();
    pins = '0;
    idle(3); reset = 1'b1;
    rd(3'd2, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_mode: got %h need 0000", v); end
    wr(3'd2, 16'h00FF);
    idle(40);
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_raw: got %h need 0000", v); end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_event: got %h need 0000", v); end
    rd(3'd3, v); n_checks++;
    if (v !== 16'h2000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL mid_status_after: got %h irq=%b need 2000 irq=0", v, irq);
    end
    rd(3'd4, v); n_checks++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL mid_pop: got %h need 0000", v); end
  endtask

  initial begin
    #1;
    test_reset;
    test_glitch;
    test_single;
    test_simultaneous;
    test_overflow;
    test_w1c;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
